// File: rtl/ysyx_23060124_mc_ctrl.sv
// Multi-cycle core sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives IFU/LSU handshakes and the RF/PC write strobes, halts on ebreak, decode error or bus timeout.
module ysyx_23060124_mc_ctrl #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic             o_ifu_req,
   input  logic             i_ifu_rvalid,
   output logic             o_ir_wen,
   input  logic             i_dec_wen,
   input  logic             i_dec_load,
   input  logic             i_dec_store,
   input  logic             i_dec_brch,
   input  logic             i_dec_jump,
   input  logic             i_dec_ebreak,
   input  logic             i_dec_err,
   input  logic             i_brch_taken,
   output logic             o_lsu_req,
   output logic             o_lsu_we,
   input  logic             i_lsu_done,
   output logic             o_rf_wen,
   output logic             o_pc_wen,
   output logic             o_pc_sel,
   output logic             o_retire,
   output logic             o_halt,
   output logic [1:0]       o_err,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_instret
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_DEC  = 2'd1;
   localparam logic [1:0] ERR_IFU  = 2'd2;
   localparam logic [1:0] ERR_LSU  = 2'd3;

   state_e           state_q, state_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [1:0]       err_q, err_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         err_q     <= ERR_NONE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      instret_d = instret_q;
      o_ifu_req = 1'b0;
      o_ir_wen  = 1'b0;
      o_lsu_req = 1'b0;
      o_lsu_we  = 1'b0;
      o_rf_wen  = 1'b0;
      o_pc_wen  = 1'b0;
      o_pc_sel  = 1'b0;
      o_retire  = 1'b0;
      // Outputs are forced quiet while reset is asserted; state still updates via the reset branch.
      if (i_rst_n) begin
         case (state_q)
            S_FETCH: begin
               o_ifu_req = 1'b1;
               if (i_ifu_rvalid) begin
                  o_ir_wen = 1'b1;
                  state_d  = S_DECODE;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_HALT;
                  err_d   = ERR_IFU;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DECODE: begin
               if (i_dec_err) begin
                  state_d = S_HALT;
                  err_d   = ERR_DEC;
               end else if (i_dec_ebreak) begin
                  state_d = S_HALT;
                  err_d   = ERR_NONE;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               if (i_dec_load | i_dec_store) begin
                  state_d = S_MEM;
                  cnt_d   = '0;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               o_lsu_req = 1'b1;
               o_lsu_we  = i_dec_store;
               if (i_lsu_done) begin
                  state_d = S_WB;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_HALT;
                  err_d   = ERR_LSU;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_WB: begin
               o_rf_wen  = i_dec_wen & ~i_dec_store;
               o_pc_wen  = 1'b1;
               o_pc_sel  = i_dec_jump | (i_dec_brch & i_brch_taken);
               o_retire  = 1'b1;
               instret_d = instret_q + 1'b1;
               state_d   = S_FETCH;
               cnt_d     = '0;
            end
            S_HALT: ;
            default: begin
               state_d = S_HALT;
               err_d   = ERR_DEC;
            end
         endcase
      end
   end

   assign o_halt    = (state_q == S_HALT);
   assign o_err     = err_q;
   assign o_state   = state_q;
   assign o_instret = instret_q;

endmodule

// File: tb/tb_ysyx_23060124_mc_ctrl.sv
// Directed self-checking bench for the multi-cycle sequencer (TIMEOUT=8).
module tb_ysyx_23060124_mc_ctrl;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ifu_req, rvalid, ir_wen;
   logic             d_wen, d_ld, d_st, d_br, d_jp, d_eb, d_er, taken;
   logic             lsu_req, lsu_we, lsu_done;
   logic             rf_wen, pc_wen, pc_sel, retire, halt;
   logic [1:0]       err;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_23060124_mc_ctrl #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_ifu_req(ifu_req), .i_ifu_rvalid(rvalid), .o_ir_wen(ir_wen),
      .i_dec_wen(d_wen), .i_dec_load(d_ld), .i_dec_store(d_st), .i_dec_brch(d_br),
      .i_dec_jump(d_jp), .i_dec_ebreak(d_eb), .i_dec_err(d_er), .i_brch_taken(taken),
      .o_lsu_req(lsu_req), .o_lsu_we(lsu_we), .i_lsu_done(lsu_done),
      .o_rf_wen(rf_wen), .o_pc_wen(pc_wen), .o_pc_sel(pc_sel), .o_retire(retire),
      .o_halt(halt), .o_err(err), .o_state(state), .o_instret(instret)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change at the falling edge; checks run 1ns later, well before the next rising edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_flags();
      {d_wen, d_ld, d_st, d_br, d_jp, d_eb, d_er, taken} = '0;
      rvalid = 1'b0;
      lsu_done = 1'b0;
   endtask

   task automatic do_reset();
      clr_flags();
      rst_n  = 1'b0;
      step();
      rvalid = 1'b1;
      #1 chk("rst_ifu_req", ifu_req, 0);
      chk("rst_ir_wen", ir_wen, 0);
      rvalid = 1'b0;
      rst_n  = 1'b1;
   endtask

   // Full instruction starting at the first FETCH cycle with rvalid present immediately.
   task automatic instr(input logic wen, ld, st, br, tk, jp, input int lsu_wait,
                        input logic exp_rf, exp_sel);
      d_wen = wen; d_ld = ld; d_st = st; d_br = br; taken = tk; d_jp = jp;
      rvalid = 1'b1;
      #1 chk("f_state", state, 0);
      chk("f_ir_wen", ir_wen, 1);
      chk("f_ifu_req", ifu_req, 1);
      step();
      rvalid = 1'b0;
      #1 chk("d_state", state, 1);
      chk("d_ir_wen", ir_wen, 0);
      step();
      #1 chk("e_state", state, 2);
      step();
      if (ld | st) begin
         for (int i = 0; i <= lsu_wait; i++) begin
            lsu_done = (i == lsu_wait);
            #1 chk("m_state", state, 3);
            chk("m_lsu_req", lsu_req, 1);
            chk("m_lsu_we", lsu_we, st);
            step();
         end
         lsu_done = 1'b0;
      end
      #1 chk("w_state", state, 4);
      chk("w_rf_wen", rf_wen, exp_rf);
      chk("w_pc_wen", pc_wen, 1);
      chk("w_pc_sel", pc_sel, exp_sel);
      chk("w_retire", retire, 1);
      chk("w_lsu_req", lsu_req, 0);
      step();
      clr_flags();
   endtask

   initial begin
      clr_flags();
      rst_n = 1'b0;
      @(negedge clk);
      do_reset();
      #1 chk("rst_state", state, 0);
      chk("rst_instret", instret, 0);
      chk("rst_err", err, 0);
      chk("rst_halt", halt, 0);

      // addi, lw (3-cycle LSU wait), sw, beq taken, bne not taken, jal
      instr(1, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("addi_state", state, 0);
      chk("addi_instret", instret, 1);
      instr(1, 1, 0, 0, 0, 0, 3, 1, 0);
      instr(1, 0, 1, 0, 0, 0, 3, 0, 0);
      instr(0, 0, 0, 1, 1, 0, 0, 0, 1);
      instr(0, 0, 0, 1, 0, 0, 0, 0, 0);
      instr(1, 0, 0, 0, 0, 1, 0, 1, 1);
      #1 chk("six_instret", instret, 6);

      // Fetch timeout: 8 FETCH cycles without rvalid, then halt with cause 2
      do_reset();
      for (int i = 0; i < 8; i++) begin
         #1 chk("to_f_state", state, 0);
         step();
      end
      #1 chk("to_f_halt_state", state, 5);
      chk("to_f_err", err, 2);
      chk("to_f_halt", halt, 1);
      chk("to_f_ifu_req", ifu_req, 0);

      // rvalid on the last allowed cycle still advances; then decode error (beats ebreak)
      do_reset();
      for (int i = 0; i < 7; i++) step();
      rvalid = 1'b1;
      #1 chk("late_ir_wen", ir_wen, 1);
      step();
      rvalid = 1'b0;
      d_er = 1'b1; d_eb = 1'b1;
      #1 chk("late_state", state, 1);
      chk("de_retire", retire, 0);
      step();
      clr_flags();
      #1 chk("de_state", state, 5);
      chk("de_err", err, 1);
      chk("de_halt", halt, 1);
      chk("de_instret", instret, 0);
      rvalid = 1'b1;
      #1 chk("halt_ir_wen", ir_wen, 0);
      step();
      rvalid = 1'b0;
      step();
      #1 chk("halt_stays", state, 5);

      // ebreak halt: cause 0, no retire
      do_reset();
      instr(1, 0, 0, 0, 0, 0, 0, 1, 0);
      rvalid = 1'b1;
      step();
      rvalid = 1'b0;
      d_eb = 1'b1;
      step();
      clr_flags();
      #1 chk("eb_state", state, 5);
      chk("eb_err", err, 0);
      chk("eb_instret", instret, 1);
      chk("eb_pc_wen", pc_wen, 0);

      // LSU timeout
      do_reset();
      d_ld = 1'b1; d_wen = 1'b1; rvalid = 1'b1;
      step();
      rvalid = 1'b0;
      step(); step();
      for (int i = 0; i < 8; i++) begin
         #1 chk("to_m_state", state, 3);
         step();
      end
      clr_flags();
      #1 chk("to_m_halt_state", state, 5);
      chk("to_m_err", err, 3);
      chk("to_m_lsu_req", lsu_req, 0);

      // Reset during MEM with done pending abandons the instruction
      do_reset();
      instr(1, 0, 0, 0, 0, 0, 0, 1, 0);
      d_st = 1'b1; rvalid = 1'b1;
      step();
      rvalid = 1'b0;
      step(); step();
      #1 chk("mr_state", state, 3);
      rst_n = 1'b0; lsu_done = 1'b1;
      #1 chk("mr_lsu_req", lsu_req, 0);
      chk("mr_rf_wen", rf_wen, 0);
      chk("mr_pc_wen", pc_wen, 0);
      step();
      clr_flags();
      rst_n = 1'b1;
      #1 chk("mr_state_after", state, 0);
      chk("mr_instret", instret, 0);
      instr(1, 0, 0, 0, 0, 0, 0, 1, 0);
      instr(1, 1, 0, 0, 0, 0, 1, 1, 0);
      instr(0, 0, 0, 0, 0, 1, 0, 0, 1);
      #1 chk("mr_instret3", instret, 3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule

// File: doc/ysyx_23060124_mc_ctrl.md
Name: ysyx_23060124_mc_ctrl

Overview:
Multi-cycle core sequencer. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It issues handshakes to the IFU and LSU and gates the register-file write and PC write.
It consumes the decode flags produced by the instruction decoder (wen, load, store, branch, jump, ebreak, decode error) plus the EXU branch-taken result. It halts the core on ebreak, decode error or bus timeout.

Parameters:
TIMEOUT, 256, max cycles to wait for i_ifu_rvalid or i_lsu_done before error halt (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, synchronous, active-low
o_ifu_req  out  1  fetch request, high throughout FETCH
i_ifu_rvalid  in  1  instruction valid from IFU
o_ir_wen  out  1  latch instruction register (same cycle as accepted rvalid)
i_dec_wen  in  1  decoder: instruction writes rd
i_dec_load  in  1  decoder: load (load_opt != 0)
i_dec_store  in  1  decoder: store (store_opt != 0)
i_dec_brch  in  1  decoder: conditional branch
i_dec_jump  in  1  decoder: jal or jalr
i_dec_ebreak  in  1  decoder: ebreak
i_dec_err  in  1  decoder: illegal opcode/func3/func7
i_brch_taken  in  1  EXU branch condition result, valid in EXEC..WB
o_lsu_req  out  1  memory request, high throughout MEM
o_lsu_we  out  1  1 = store, 0 = load; valid with o_lsu_req
i_lsu_done  in  1  LSU completion pulse
o_rf_wen  out  1  register-file write strobe
o_pc_wen  out  1  PC update strobe
o_pc_sel  out  1  0 = pc+4, 1 = jump/branch target
o_retire  out  1  one-cycle pulse per retired instruction
o_halt  out  1  core halted (sticky)
o_err  out  2  halt cause: 0 none/ebreak, 1 decode error, 2 fetch timeout, 3 LSU timeout
o_state  out  3  current state encoding (debug)
o_instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Values 6 and 7 are illegal and go to HALT with o_err=1.
- Reset (i_rst_n=0 at edge):
  - state=FETCH, timeout counter=0, o_instret=0, o_err=0, o_halt=0.
  - All strobes are 0 during the reset cycle, including o_ifu_req.
  - Reset mid-instruction abandons it: no rf/pc write; a pending rvalid/done in that cycle is ignored.
- FETCH:
  - o_ifu_req=1.
  - On i_ifu_rvalid: o_ir_wen=1 combinationally that cycle; next state DECODE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without rvalid: HALT, o_err=2.
  - rvalid in the same cycle the counter hits TIMEOUT-1 wins (normal advance).
- DECODE (1 cycle). Priority order:
  - i_dec_err -> HALT, o_err=1.
  - else i_dec_ebreak -> HALT, o_err=0.
  - else EXEC.
- EXEC (1 cycle): i_dec_load|i_dec_store -> MEM; else WB. Load and store both high is treated as store.
- MEM:
  - o_lsu_req=1, o_lsu_we=i_dec_store. The counter is cleared on entry.
  - On i_lsu_done: WB. Otherwise timeout as in FETCH, with o_err=3.
- WB (1 cycle), all strobes asserted this cycle only:
  - o_rf_wen = i_dec_wen & ~i_dec_store.
  - o_pc_wen=1.
  - o_pc_sel = i_dec_jump | (i_dec_brch & i_brch_taken).
  - o_retire=1, o_instret increments (wraps at 2^CNT_W).
  - Next state FETCH.
- Minimum latency: non-memory instruction = 4 cycles when rvalid arrives in the first FETCH cycle; memory instruction = 5 + LSU wait.
- HALT:
  - o_halt=1; all strobes 0; o_err and o_instret frozen.
  - Only reset exits HALT. An ebreak halt does not increment o_instret.
- Ignored inputs: i_ifu_rvalid outside FETCH and i_lsu_done outside MEM have no effect.
- Strobes (o_ir_wen, o_rf_wen, o_pc_wen, o_retire) are never high outside their stated state.
- The timeout counter is cleared on every FETCH and MEM entry. Width is clog2(TIMEOUT).

Test Plan:
- addi, rvalid on first FETCH cycle -> states 0,1,2,4,0; o_rf_wen=1 and o_pc_sel=0 in cycle 4; o_instret=1.
- lw, i_lsu_done 3 cycles after MEM entry -> o_lsu_req high 4 cycles with o_lsu_we=0; then WB with o_rf_wen=1. sw same flow -> o_lsu_we=1 and o_rf_wen=0 in WB.
- beq with i_brch_taken=1 -> o_pc_sel=1 in WB, o_rf_wen=0. bne with taken=0 -> o_pc_sel=0. jal (dec_jump=1, dec_wen=1) -> o_pc_sel=1, o_rf_wen=1.
- i_dec_err=1 in DECODE -> HALT, o_err=1, o_halt=1, no retire. ebreak -> HALT, o_err=0. Later rvalid pulses cause no state change.
- TIMEOUT=8, rvalid withheld -> HALT after 8 FETCH cycles with o_err=2. Repeat with rvalid on cycle 8 -> normal DECODE. LSU withheld -> o_err=3.
- Reset asserted during MEM while i_lsu_done=1 -> next state FETCH, o_instret=0, no rf/pc write. Run 3 instructions afterwards -> o_instret=3.
